// File: rtl/bus_register_bank_if.sv
// ---------------------------------------------------------------------------
// bus_register_bank_if
//
// Groups the datapath-bus signals exchanged between the register bank and
// the rest of the datapath (controller, ALU, memory, bus mux).
//
//   Control / data into the bank:
//     BusMuxOut, in_select, in_en   - bus write to a selected register
//     Z_in, Zdata                   - 64-bit ALU result into Zhigh/Zlow
//     MDR_in, mem_read, Mdata_in    - MDR load and its source select
//     MAR_in                        - MAR load from the bus
//     PC_inc                        - PC increment
//     BAout                         - zero-gating of the R0 bus-mux input
//   Data out of the bank:
//     BusMuxIn_*                    - register contents feeding the bus mux
//     MAR_out                       - memory address
//     write_err                     - one-cycle pulse on an illegal write
//
// The slave modport belongs to the register bank and the master modport
// belongs to whatever drives it.
// ---------------------------------------------------------------------------
interface bus_register_bank_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   BusMuxOut;
    logic [4:0]              in_select;
    logic                    in_en;
    logic                    Z_in;
    logic [2*DATA_WIDTH-1:0] Zdata;
    logic                    MDR_in;
    logic                    mem_read;
    logic [DATA_WIDTH-1:0]   Mdata_in;
    logic                    MAR_in;
    logic                    PC_inc;
    logic                    BAout;

    logic [DATA_WIDTH-1:0]   BusMuxIn_R0,  BusMuxIn_R1,  BusMuxIn_R2,  BusMuxIn_R3;
    logic [DATA_WIDTH-1:0]   BusMuxIn_R4,  BusMuxIn_R5,  BusMuxIn_R6,  BusMuxIn_R7;
    logic [DATA_WIDTH-1:0]   BusMuxIn_R8,  BusMuxIn_R9,  BusMuxIn_R10, BusMuxIn_R11;
    logic [DATA_WIDTH-1:0]   BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15;
    logic [DATA_WIDTH-1:0]   BusMuxIn_HI,  BusMuxIn_LO;
    logic [DATA_WIDTH-1:0]   BusMuxIn_Zhigh, BusMuxIn_Zlow;
    logic [DATA_WIDTH-1:0]   BusMuxIn_PC,  BusMuxIn_MDR;
    logic [DATA_WIDTH-1:0]   MAR_out;
    logic                    write_err;

    modport slave (
        input  BusMuxOut, in_select, in_en, Z_in, Zdata, MDR_in, mem_read,
               Mdata_in, MAR_in, PC_inc, BAout,
        output BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
               BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
               BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
               BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
               BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_Zhigh, BusMuxIn_Zlow,
               BusMuxIn_PC, BusMuxIn_MDR, MAR_out, write_err
    );

    modport master (
        output BusMuxOut, in_select, in_en, Z_in, Zdata, MDR_in, mem_read,
               Mdata_in, MAR_in, PC_inc, BAout,
        input  BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
               BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
               BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
               BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
               BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_Zhigh, BusMuxIn_Zlow,
               BusMuxIn_PC, BusMuxIn_MDR, MAR_out, write_err
    );
endinterface

// File: rtl/bus_register_bank.sv
// ---------------------------------------------------------------------------
// bus_register_bank
//
// Write side of the datapath bus. Holds R0-R15, HI, LO, Zhigh, Zlow, PC,
// MDR and MAR, loads them from the bus (or from their dedicated sources) on
// the rising clock edge, and presents their contents as bus-mux inputs.
//
// Ports:
//   clock - rising-edge clock
//   clear - synchronous active-high reset, dominates every load
//   bus   - bus_register_bank_if.slave (bus write, Z/MDR/MAR/PC controls,
//           register outputs, write_err)
//
// Destination codes (same as the bus-mux source select):
//   0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR; every other code is illegal
//   for a bus write and raises write_err for one cycle.
// ---------------------------------------------------------------------------
module bus_register_bank #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       clear,
    bus_register_bank_if.slave         bus
);
    logic [DATA_WIDTH-1:0] gpr_q [16];
    logic [DATA_WIDTH-1:0] gpr_d [16];
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] zhigh_q, zhigh_d;
    logic [DATA_WIDTH-1:0] zlow_q, zlow_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0] mar_q, mar_d;
    logic                  write_err_q, write_err_d;

    // Next-state computation. Assignment order encodes the priorities:
    // a bus write to PC overrides the increment, and a memory-sourced MDR
    // load overrides a bus write to MDR.
    always_comb begin
        gpr_d       = gpr_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        zhigh_d     = zhigh_q;
        zlow_d      = zlow_q;
        mdr_d       = mdr_q;
        mar_d       = mar_q;
        write_err_d = 1'b0;
        pc_d        = bus.PC_inc ? pc_q + DATA_WIDTH'(1) : pc_q;

        if (bus.in_en) begin
            if (!bus.in_select[4]) begin
                gpr_d[bus.in_select[3:0]] = bus.BusMuxOut;
            end else begin
                case (bus.in_select[3:0])
                    4'd0:    hi_d        = bus.BusMuxOut;
                    4'd1:    lo_d        = bus.BusMuxOut;
                    4'd4:    pc_d        = bus.BusMuxOut;
                    4'd5:    mdr_d       = bus.BusMuxOut;
                    default: write_err_d = 1'b1;
                endcase
            end
        end

        if (bus.MDR_in) begin
            mdr_d = bus.mem_read ? bus.Mdata_in : bus.BusMuxOut;
        end

        if (bus.Z_in) begin
            zhigh_d = bus.Zdata[2*DATA_WIDTH-1:DATA_WIDTH];
            zlow_d  = bus.Zdata[DATA_WIDTH-1:0];
        end

        if (bus.MAR_in) begin
            mar_d = bus.BusMuxOut;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q        <= '0;
            lo_q        <= '0;
            zhigh_q     <= '0;
            zlow_q      <= '0;
            pc_q        <= '0;
            mdr_q       <= '0;
            mar_q       <= '0;
            write_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            zhigh_q     <= zhigh_d;
            zlow_q      <= zlow_d;
            pc_q        <= pc_d;
            mdr_q       <= mdr_d;
            mar_q       <= mar_d;
            write_err_q <= write_err_d;
        end
    end

    // R0 reads as zero while BAout is asserted (base-address gating); the
    // stored value is untouched.
    assign bus.BusMuxIn_R0    = bus.BAout ? '0 : gpr_q[0];
    assign bus.BusMuxIn_R1    = gpr_q[1];
    assign bus.BusMuxIn_R2    = gpr_q[2];
    assign bus.BusMuxIn_R3    = gpr_q[3];
    assign bus.BusMuxIn_R4    = gpr_q[4];
    assign bus.BusMuxIn_R5    = gpr_q[5];
    assign bus.BusMuxIn_R6    = gpr_q[6];
    assign bus.BusMuxIn_R7    = gpr_q[7];
    assign bus.BusMuxIn_R8    = gpr_q[8];
    assign bus.BusMuxIn_R9    = gpr_q[9];
    assign bus.BusMuxIn_R10   = gpr_q[10];
    assign bus.BusMuxIn_R11   = gpr_q[11];
    assign bus.BusMuxIn_R12   = gpr_q[12];
    assign bus.BusMuxIn_R13   = gpr_q[13];
    assign bus.BusMuxIn_R14   = gpr_q[14];
    assign bus.BusMuxIn_R15   = gpr_q[15];
    assign bus.BusMuxIn_HI    = hi_q;
    assign bus.BusMuxIn_LO    = lo_q;
    assign bus.BusMuxIn_Zhigh = zhigh_q;
    assign bus.BusMuxIn_Zlow  = zlow_q;
    assign bus.BusMuxIn_PC    = pc_q;
    assign bus.BusMuxIn_MDR   = mdr_q;
    assign bus.MAR_out        = mar_q;
    assign bus.write_err      = write_err_q;

endmodule

// File: tb/tb_bus_register_bank.sv
// ---------------------------------------------------------------------------
// tb_bus_register_bank
//
// Drives bus_register_bank with directed vectors plus a short random burst.
// A behavioural model of the register file tracks what every output must
// hold; a compare process checks all outputs against it each cycle, and
// hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_bus_register_bank;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic clear;

    bus_register_bank_if #(.DATA_WIDTH(DW)) bus ();

    bus_register_bank #(.DATA_WIDTH(DW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic checkEnable = 1'b0;

    // Model state: one slot per register, named by what it is rather than
    // how the design stores it.
    logic [DW-1:0] mR [16];
    logic [DW-1:0] mHi, mLo, mZh, mZl, mPc, mMdr, mMar;
    logic          mErr;

    function automatic bit isLegal(input logic [4:0] code);
        return (code <= 5'd17) || (code == 5'd20) || (code == 5'd21);
    endfunction

    // Model update from the inputs present at the rising edge.
    always @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) mR[i] = '0;
            {mHi, mLo, mZh, mZl, mPc, mMdr, mMar} = '0;
            mErr = 1'b0;
        end else begin
            logic [DW-1:0] oldPc;
            oldPc = mPc;
            mErr  = bus.in_en && !isLegal(bus.in_select);
            if (bus.PC_inc) mPc = oldPc + 32'd1;
            if (bus.in_en) begin
                if (bus.in_select < 16)        mR[bus.in_select[3:0]] = bus.BusMuxOut;
                else if (bus.in_select == 16)  mHi  = bus.BusMuxOut;
                else if (bus.in_select == 17)  mLo  = bus.BusMuxOut;
                else if (bus.in_select == 20)  mPc  = bus.BusMuxOut;
                else if (bus.in_select == 21)  mMdr = bus.BusMuxOut;
            end
            if (bus.MDR_in) mMdr = bus.mem_read ? bus.Mdata_in : bus.BusMuxOut;
            if (bus.Z_in) begin
                mZh = bus.Zdata[63:32];
                mZl = bus.Zdata[31:0];
            end
            if (bus.MAR_in) mMar = bus.BusMuxOut;
        end
    end

    function automatic logic [DW-1:0] rOut(input int i);
        case (i)
            0:  return bus.BusMuxIn_R0;   1:  return bus.BusMuxIn_R1;
            2:  return bus.BusMuxIn_R2;   3:  return bus.BusMuxIn_R3;
            4:  return bus.BusMuxIn_R4;   5:  return bus.BusMuxIn_R5;
            6:  return bus.BusMuxIn_R6;   7:  return bus.BusMuxIn_R7;
            8:  return bus.BusMuxIn_R8;   9:  return bus.BusMuxIn_R9;
            10: return bus.BusMuxIn_R10;  11: return bus.BusMuxIn_R11;
            12: return bus.BusMuxIn_R12;  13: return bus.BusMuxIn_R13;
            14: return bus.BusMuxIn_R14;  default: return bus.BusMuxIn_R15;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model, away from the edge.
    always @(negedge clock) begin
        if (checkEnable) begin
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("R%0d", i), rOut(i),
                            (i == 0 && bus.BAout) ? '0 : mR[i]);
            end
            checkOutput("HI", bus.BusMuxIn_HI, mHi);
            checkOutput("LO", bus.BusMuxIn_LO, mLo);
            checkOutput("Zhigh", bus.BusMuxIn_Zhigh, mZh);
            checkOutput("Zlow", bus.BusMuxIn_Zlow, mZl);
            checkOutput("PC", bus.BusMuxIn_PC, mPc);
            checkOutput("MDR", bus.BusMuxIn_MDR, mMdr);
            checkOutput("MAR", bus.MAR_out, mMar);
            checkOutput("write_err", {31'b0, bus.write_err}, {31'b0, mErr});
        end
    end

    // Advance one clock: returns just after the falling edge, so the
    // rising edge in between has consumed the previously driven inputs.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        clear        = 1'b0;
        bus.BusMuxOut = '0;
        bus.in_select = '0;
        bus.in_en     = 1'b0;
        bus.Z_in      = 1'b0;
        bus.Zdata     = '0;
        bus.MDR_in    = 1'b0;
        bus.mem_read  = 1'b0;
        bus.Mdata_in  = '0;
        bus.MAR_in    = 1'b0;
        bus.PC_inc    = 1'b0;
        bus.BAout     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] sel, input logic [DW-1:0] val);
        idle();
        bus.in_en     = 1'b1;
        bus.in_select = sel;
        bus.BusMuxOut = val;
        tick();
        idle();
    endtask

    initial begin
        idle();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        checkEnable = 1'b1;

        // Reset discards a concurrent write and all other loads.
        applyStimulus(5'd3, 32'h12345678);
        checkOutput("lit R3 load", bus.BusMuxIn_R3, 32'h12345678);
        clear = 1'b1;
        bus.in_en = 1'b1; bus.in_select = 5'd3; bus.BusMuxOut = 32'h55;
        bus.Z_in = 1'b1; bus.Zdata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.MAR_in = 1'b1; bus.PC_inc = 1'b1;
        tick();
        idle();
        checkOutput("lit R3 clear", bus.BusMuxIn_R3, 32'h0);
        checkOutput("lit PC clear", bus.BusMuxIn_PC, 32'h0);
        checkOutput("lit Zhigh clear", bus.BusMuxIn_Zhigh, 32'h0);
        checkOutput("lit werr clear", {31'b0, bus.write_err}, 32'h0);

        // Bus write to R0 and BAout gating within the same cycle.
        applyStimulus(5'd0, 32'hDEADBEEF);
        checkOutput("lit R0 write", bus.BusMuxIn_R0, 32'hDEADBEEF);
        bus.BAout = 1'b1;
        #1;
        checkOutput("lit R0 gated", bus.BusMuxIn_R0, 32'h0);
        bus.BAout = 1'b0;
        #1;
        checkOutput("lit R0 ungated", bus.BusMuxIn_R0, 32'hDEADBEEF);

        // Illegal destinations: one-cycle error pulse, no state change.
        applyStimulus(5'd18, 32'hCAFEF00D);
        checkOutput("lit werr 18", {31'b0, bus.write_err}, 32'h1);
        tick();
        checkOutput("lit werr drop", {31'b0, bus.write_err}, 32'h0);
        applyStimulus(5'd25, 32'hCAFEF00D);
        checkOutput("lit werr 25", {31'b0, bus.write_err}, 32'h1);
        checkOutput("lit R0 hold", bus.BusMuxIn_R0, 32'hDEADBEEF);
        tick();

        // Sweep every destination code once.
        for (int c = 0; c < 32; c++) begin
            applyStimulus(5'(c), 32'hA5000000 | 32'(c * 17));
        end
        checkOutput("lit HI sweep", bus.BusMuxIn_HI, 32'hA5000000 | 32'(16 * 17));
        checkOutput("lit LO sweep", bus.BusMuxIn_LO, 32'hA5000000 | 32'(17 * 17));

        // Z, MAR and a bus write all in one edge.
        idle();
        bus.Z_in = 1'b1; bus.Zdata = 64'h00000001_80000000;
        bus.MAR_in = 1'b1; bus.in_en = 1'b1; bus.in_select = 5'd7;
        bus.BusMuxOut = 32'h40;
        tick();
        idle();
        checkOutput("lit Zhigh", bus.BusMuxIn_Zhigh, 32'h1);
        checkOutput("lit Zlow", bus.BusMuxIn_Zlow, 32'h80000000);
        checkOutput("lit MAR", bus.MAR_out, 32'h40);
        checkOutput("lit R7", bus.BusMuxIn_R7, 32'h40);

        // MDR source priority.
        for (int m = 1; m >= 0; m--) begin
            idle();
            bus.MDR_in = 1'b1; bus.mem_read = m[0]; bus.Mdata_in = 32'hAAAA5555;
            bus.in_en = 1'b1; bus.in_select = 5'd21; bus.BusMuxOut = 32'h1111;
            tick();
            idle();
            checkOutput($sformatf("lit MDR mem_read=%0d", m), bus.BusMuxIn_MDR,
                        m ? 32'hAAAA5555 : 32'h1111);
        end

        // PC wraparound, write-over-increment priority, then increments.
        applyStimulus(5'd20, 32'hFFFFFFFF);
        bus.PC_inc = 1'b1;
        tick();
        idle();
        checkOutput("lit PC wrap", bus.BusMuxIn_PC, 32'h0);
        bus.PC_inc = 1'b1; bus.in_en = 1'b1; bus.in_select = 5'd20;
        bus.BusMuxOut = 32'h100;
        tick();
        idle();
        checkOutput("lit PC write wins", bus.BusMuxIn_PC, 32'h100);
        bus.PC_inc = 1'b1;
        tick(); tick(); tick();
        idle();
        checkOutput("lit PC +3", bus.BusMuxIn_PC, 32'h103);

        // Short random burst against the model.
        for (int n = 0; n < 60; n++) begin
            clear         = ($urandom_range(0, 19) == 0);
            bus.BusMuxOut = $urandom;
            bus.in_select = 5'($urandom_range(0, 31));
            bus.in_en     = 1'($urandom_range(0, 1));
            bus.Z_in      = 1'($urandom_range(0, 1));
            bus.Zdata     = {$urandom, $urandom};
            bus.MDR_in    = 1'($urandom_range(0, 1));
            bus.mem_read  = 1'($urandom_range(0, 1));
            bus.Mdata_in  = $urandom;
            bus.MAR_in    = 1'($urandom_range(0, 1));
            bus.PC_inc    = 1'($urandom_range(0, 1));
            bus.BAout     = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        tick();

        checkEnable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
